// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared CGRA bus with a one-cycle turnaround between owners.
// Optional hold-time limit with forced revocation is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NUM_PE   = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PE-1:0] bus_request,
  output logic [NUM_PE-1:0] grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              bus_busy,
  output logic              hold_timeout
);

  // state | meaning
  // IDLE  | no owner, arbitrate among eligible requests
  // OWN   | one grant bit set, held until the owner releases
  // TURN  | dead cycle after release so bus drivers never overlap
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arbState_t;

  if (NUM_PE < 2 || NUM_PE > 16) begin : gBadNumPe
    $error("bus_arbiter: NUM_PE out of range");
  end
  if ((1 << ID_W) < NUM_PE || (1 << (ID_W - 1)) >= NUM_PE) begin : gBadIdW
    $error("bus_arbiter: ID_W must equal ceil(log2(NUM_PE))");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 65535) begin : gBadHoldMax
    $error("bus_arbiter: HOLD_MAX out of range");
  end

  localparam logic [ID_W-1:0] RESET_ID = ID_W'(NUM_PE - 1);

  arbState_t         stateQ;
  arbState_t         stateD;
  logic [NUM_PE-1:0] grantD;
  logic [ID_W-1:0]   grantIdD;
  logic [NUM_PE-1:0] eligible;
  logic [NUM_PE-1:0] pickOneHot;
  logic [ID_W-1:0]   pickId;
  logic              pickValid;
  logic              ownerReq;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

  logic [15:0]       holdCntQ;
  logic [15:0]       holdCntD;
  logic [NUM_PE-1:0] maskQ;
  logic [NUM_PE-1:0] maskD;
  logic              timeoutD;

  // A revoked PE stays masked until it is seen with its request low.
  assign eligible = bus_request & ~maskQ;
`else
  assign eligible     = bus_request;
  assign hold_timeout = 1'b0;
`endif

  assign ownerReq = bus_request[grant_id];

  // Search starts one past the pointer and wraps modulo NUM_PE, pointer itself last.
  always_comb begin
    int            idx;
    logic [ID_W-1:0] idxBits;
    pickValid  = 1'b0;
    pickId     = grant_id;
    pickOneHot = '0;
    idx        = 0;
    idxBits    = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      idx     = (int'(grant_id) + k) % NUM_PE;
      idxBits = ID_W'(idx);
      if (!pickValid && eligible[idxBits]) begin
        pickValid           = 1'b1;
        pickId              = idxBits;
        pickOneHot[idxBits] = 1'b1;
      end
    end
  end

  always_comb begin
    stateD   = stateQ;
    grantD   = grant;
    grantIdD = grant_id;
`ifdef BUS_ARB_TIMEOUT_EN
    holdCntD = holdCntQ;
    maskD    = maskQ & bus_request;
    timeoutD = 1'b0;
`endif
    unique case (stateQ)
      IDLE: begin
        if (pickValid) begin
          grantD   = pickOneHot;
          grantIdD = pickId;
          stateD   = OWN;
`ifdef BUS_ARB_TIMEOUT_EN
          holdCntD = '0;
`endif
        end
      end
      OWN: begin
        if (!ownerReq) begin
          grantD = '0;
          stateD = TURN;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (holdCntQ == HOLD_LAST) begin
          grantD          = '0;
          stateD          = TURN;
          timeoutD        = 1'b1;
          maskD[grant_id] = 1'b1;
        end else begin
          holdCntD = holdCntQ + 16'd1;
        end
`endif
      end
      TURN: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
        grantD = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ   <= IDLE;
      grant    <= '0;
      grant_id <= RESET_ID;
      bus_busy <= 1'b0;
    end else begin
      stateQ   <= stateD;
      grant    <= grantD;
      grant_id <= grantIdD;
      bus_busy <= |grantD;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      holdCntQ     <= '0;
      maskQ        <= '0;
      hold_timeout <= 1'b0;
    end else begin
      holdCntQ     <= holdCntD;
      maskQ        <= maskD;
      hold_timeout <= timeoutD;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for reset/single-owner behaviour plus
// hand-written round-robin, mid-ownership reset and hold-timeout sequences.
module tb_bus_arbiter;
  localparam int NPE  = 4;
  localparam int IDW  = 2;
  localparam int HMAX = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [NPE-1:0] bus_request;
  logic [NPE-1:0] grant;
  logic [IDW-1:0] grant_id;
  logic           bus_busy;
  logic           hold_timeout;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_PE(NPE), .ID_W(IDW), .HOLD_MAX(HMAX)) dut (
    .clk(clk),
    .reset(reset),
    .bus_request(bus_request),
    .grant(grant),
    .grant_id(grant_id),
    .bus_busy(bus_busy),
    .hold_timeout(hold_timeout)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] expGrant;
    logic [1:0] expId;
    logic       expBusy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    reset = r;
    bus_request = q;
    @(posedge clk);
    #1;
    check("grant_onehot0", int'($onehot0(grant)), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int gap;
    int guard;
    int holdLen;
    int toCount;
    int otherSeen;
    int nonZero;

    reset = 1'b0;
    bus_request = '0;

    // rst, req, grant, id, busy
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd3, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd3, 1'b0};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[6]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[7]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[8]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[9]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[10] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[11] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].expGrant));
      check($sformatf("vec%0d_id", i), int'(grant_id), int'(vecs[i].expId));
      check($sformatf("vec%0d_busy", i), int'(bus_busy), int'(vecs[i].expBusy));
      check($sformatf("vec%0d_timeout", i), int'(hold_timeout), 0);
    end

    // Round-robin: every PE requests, each owner holds 3 cycles then drops for one.
    order = '{0, 1, 2, 3, 0};
    step(1'b0, 4'b0000);
    step(1'b1, 4'b1111);
    gap = 0;
    for (int n = 0; n < 5; n++) begin
      guard = 0;
      while (grant == 4'b0000 && guard < 10) begin
        step(1'b1, 4'b1111);
        guard++;
        if (grant == 4'b0000) gap++;
      end
      check($sformatf("rr%0d_owner", n), int'(grant), 1 << order[n]);
      check($sformatf("rr%0d_busy", n), int'(bus_busy), 1);
      if (n > 0) check($sformatf("rr%0d_gap", n), gap, 2);
      step(1'b1, 4'b1111);
      step(1'b1, 4'b1111);
      check($sformatf("rr%0d_hold", n), int'(grant), 1 << order[n]);
      step(1'b1, 4'b1111 & ~(4'b0001 << order[n]));
      check($sformatf("rr%0d_release", n), int'(grant), 0);
      gap = 1;
    end

    // Reset in the middle of an ownership.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0010);
    check("midrst_own_grant", int'(grant), 4'b0010);
    check("midrst_own_id", int'(grant_id), 1);
    step(1'b0, 4'b0010);
    check("midrst_grant", int'(grant), 0);
    check("midrst_id", int'(grant_id), 3);
    check("midrst_busy", int'(bus_busy), 0);
    step(1'b1, 4'b0011);
    check("midrst_after_grant", int'(grant), 4'b0001);
    check("midrst_after_id", int'(grant_id), 0);

    // PE 2 holds its request continuously while PE 3 also requests.
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0100);
    check("to_first_grant", int'(grant), 4'b0100);
    holdLen = 1;
    toCount = 0;
    otherSeen = 0;
    guard = 0;
    while (grant == 4'b0100 && guard < 199) begin
      step(1'b1, 4'b1100);
      guard++;
      if (hold_timeout) toCount++;
      if (grant == 4'b0100) holdLen++;
      if (grant[3]) otherSeen++;
    end
`ifdef BUS_ARB_TIMEOUT_EN
    check("to_hold_len", holdLen, HMAX);
    check("to_pulse_now", int'(hold_timeout), 1);
    check("to_revoked_grant", int'(grant), 0);
    step(1'b1, 4'b1100);
    check("to_pulse_end", int'(hold_timeout), 0);
    check("to_idle_grant", int'(grant), 0);
    step(1'b1, 4'b1100);
    check("to_pe3_grant", int'(grant), 4'b1000);
    check("to_pe3_id", int'(grant_id), 3);
    step(1'b1, 4'b1100);
    check("to_pe3_hold", int'(grant), 4'b1000);
    if (hold_timeout) toCount++;
    check("to_pulse_count", toCount, 1);
    step(1'b1, 4'b0100);
    check("to_pe3_release", int'(grant), 0);
    nonZero = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0100);
      if (grant != 4'b0000) nonZero++;
    end
    check("to_pe2_masked", nonZero, 0);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0100);
    check("to_pe2_regrant", int'(grant), 4'b0100);
`else
    check("noto_hold_len", holdLen, 200);
    check("noto_pulse_count", toCount, 0);
    check("noto_pe3_seen", otherSeen, 0);
    check("noto_still_owner", int'(grant), 4'b0100);
    check("noto_id", int'(grant_id), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single global bus among `NUM_PE` processing-element bus interfaces in the CGRA. Each PE's bus interface raises `bus_request` and waits for its `grant` bit. The arbiter issues one-hot grants and holds ownership until the owner drops its request. It inserts one turnaround cycle between owners, so bus-side address and control lines never see two drivers.

## Interface
- `NUM_PE`, default 4: number of requesting PE bus interfaces; legal range 2..16.
- `ID_W`, default 2: width of `grant_id`; must equal ceil(log2(`NUM_PE`)).
- `HOLD_MAX`, default 64: maximum cycles one owner may hold the bus. Used only with `BUS_ARB_TIMEOUT_EN`. Legal range 2..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-low. The block resets at a rising `clk` edge where `reset`=0.
- `bus_request`  in  `NUM_PE`  per-PE request; bit i driven by PE i's bus interface.
- `grant`  out  `NUM_PE`  one-hot grant to the owner; all-zero when there is no owner.
- `grant_id`  out  `ID_W`  binary index of the current or most recent owner.
- `bus_busy`  out  1  high while any grant bit is set.
- `hold_timeout`  out  1  one-cycle pulse when an owner is forcibly revoked. Constant 0 without the macro.

## Operation
- Three-state FSM, all outputs registered:
  - `IDLE`: no owner.
  - `OWN`: one grant bit set.
  - `TURN`: one dead cycle after release.
- Reset values: state=`IDLE`, `grant`=0, `grant_id`=`NUM_PE`-1 (so PE 0 has first priority), `bus_busy`=0, `hold_timeout`=0, hold counter=0.
- Round-robin pointer is `grant_id`. Search order is `grant_id`+1, `grant_id`+2, … modulo `NUM_PE`, wrapping to `grant_id` itself last.
- `IDLE`:
  - If any `bus_request` bit is set: select the first set bit in search order, load `grant` one-hot and `grant_id`, go to `OWN`.
  - Otherwise stay in `IDLE`.
- `OWN`:
  - If `bus_request[grant_id]`=0: clear `grant`, go to `TURN`. `grant_id` is retained as the new pointer.
  - Otherwise hold the grant. Requests from other PEs are ignored; there is no preemption.
- `TURN`:
  - `grant`=0 for exactly one cycle, then go to `IDLE`.
  - A new owner can be granted at the end of the following cycle.
- Requests may assert or deassert at any time. Non-owners are never latched; a request pulse that drops before arbitration samples it is lost.
- An owner that re-requests immediately after release competes normally. It is last in search order, so with another requester present it loses.
- `NUM_PE` not a power of two: indices ≥ `NUM_PE` are never selected. Pointer wrap is computed modulo `NUM_PE`, not 2^`ID_W`.
- `reset`=0 in any state, including mid-ownership: `grant` clears at that same edge, no `TURN` cycle is inserted, and all reset values apply.

## Timing
- Grant latency from `IDLE`: request high before edge N → `grant` high after edge N, i.e. visible in cycle N+1.
- Release latency: owner `bus_request` low before edge N → `grant` low after edge N.
- Owner handoff: if the next requester is already pending, the next grant rises after edge N+2. This gives 2 grant-low cycles between owners: the `TURN` cycle plus one `IDLE` cycle.
- Invariant at every cycle: `grant` is one-hot or zero.
- `bus_busy` equals |`grant` at every cycle.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - A 16-bit hold counter clears on entry to `OWN` and increments each `OWN` cycle.
  - When the counter reaches `HOLD_MAX`-1 with the owner still requesting, `grant` clears at that edge, the FSM enters `TURN`, and `hold_timeout` pulses high for one cycle.
  - The revoked PE must drop and re-raise its request to compete again. Until it sees its request low, the arbiter masks it out of selection.
- `BUS_ARB_TIMEOUT_EN` not defined:
  - No counter and no mask are built. `hold_timeout` is tied 0.
  - Ownership is unbounded.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `bus_request`=4'b1111. Required: `grant`=0, `grant_id`=3, `bus_busy`=0 throughout. After release, `grant`=4'b0001 one cycle later.
- Single requester: `bus_request`=4'b0100 for 5 cycles, then 0. Required: `grant`=4'b0100 from cycle 1 to cycle 5, `grant_id`=2. `grant` returns to 0 one cycle after the request drops.
- Round-robin fairness: `bus_request`=4'b1111, each owner drops its request for one cycle after holding 3 cycles. Required grant order 0,1,2,3,0, with exactly 2 zero-grant cycles between owners.
- Mid-ownership reset: PE 1 owns the bus, `reset`=0 for one cycle. Required: `grant`=0 the next cycle and `grant_id`=3. Afterwards, with `bus_request`=4'b0011, PE 0 wins.
- Timeout (macro on, `HOLD_MAX`=8): PE 2 holds its request continuously while PE 3 also requests. Required: PE 2 `grant` high for exactly 8 cycles, `hold_timeout` pulses once, then PE 3 is granted. PE 2 is not re-granted until its request toggles low.
- Timeout (macro off): same stimulus. Required: PE 2 keeps the grant for 200 cycles, `hold_timeout` stays 0, and PE 3 is never granted.
